// File: rtl/f_stage_pc_pkg.sv
// f_stage_pc_pkg: constants shared by the fetch stage and its F/D register.
//   - Exception codes written into the F/D register.
//   - Default reset / handler PCs and the legal instruction-memory window.
//   - BOOT/RUN state encodings for the fetch FSM.
//   - is_adel(): fetch address-error test for a PC.
package f_stage_pc_pkg;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
  localparam logic [31:0] IM_LO_DEF      = 32'h0000_3000;
  localparam logic [31:0] IM_HI_DEF      = 32'h0000_6ffc;

  localparam logic [0:0] ST_BOOT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // A fetch faults when the PC is not word aligned or lies outside [lo, hi].
  function automatic logic is_adel(input logic [31:0] pc,
                                   input logic [31:0] lo,
                                   input logic [31:0] hi);
    return (pc[1:0] != 2'b00) || (pc < lo) || (pc > hi);
  endfunction

endpackage

// File: rtl/f_stage_pc_fd_reg.sv
// fd_reg: F/D pipeline register.
//   clk, reset     : clock, synchronous active-low reset
//   en             : load new contents (deasserted on a stall)
//   flush          : load a bubble instead; wins over en
//   bubble_pc      : PC value carried by a bubble
//   in_*           : F-stage values {pc, instr, exccode, bd}
//   d_*            : registered D-stage values
// Priority on each edge: reset, flush, en, hold.
module fd_reg
  import f_stage_pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        flush,
  input  logic [31:0] bubble_pc,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  input  logic [4:0]  in_exccode,
  input  logic        in_bd,
  output logic [31:0] d_pc,
  output logic [31:0] d_instr,
  output logic [4:0]  d_exccode,
  output logic        d_bd
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      d_pc      <= RESET_PC;
      d_instr   <= 32'd0;
      d_exccode <= EXC_NONE;
      d_bd      <= 1'b0;
    end else if (flush) begin
      // A bubble is a nop with no exception and no delay-slot marking.
      d_pc      <= bubble_pc;
      d_instr   <= 32'd0;
      d_exccode <= EXC_NONE;
      d_bd      <= 1'b0;
    end else if (en) begin
      d_pc      <= in_pc;
      d_instr   <= in_instr;
      d_exccode <= in_exccode;
      d_bd      <= in_bd;
    end
  end

endmodule

// File: rtl/f_stage_pc.sv
// f_stage_pc: fetch stage of a 5-stage MIPS pipeline with precise exceptions.
// Holds the PC, drives the instruction-memory address, flags fetch address
// errors (AdEL) and owns the F/D pipeline register.
//   clk, reset    : clock, synchronous active-low reset
//   npc           : next PC from the D-stage next-PC logic
//   stall         : hold PC and F/D
//   req           : exception/interrupt taken (overrides stall)
//   eret          : eret in D; redirect to npc (EPC), no delay slot
//   D_is_jump     : next fetch is a delay slot
//   i_inst_addr   : instruction memory address (= F_pc)
//   i_inst_rdata  : instruction word, combinational read
//   F_pc          : current fetch PC
//   D_pc, D_instr, D_exccode, D_bd : F/D register outputs
//   perf_fetch, perf_stall : performance counters
// Optional feature macro: FETCH_PERF_EN. When undefined, no counter
// registers exist and both perf outputs are tied to 0.
// The FSM state is visible as the internal signal fsm_state.
module f_stage_pc
  import f_stage_pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF,
  parameter logic [31:0] IM_LO      = IM_LO_DEF,
  parameter logic [31:0] IM_HI      = IM_HI_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc,
  input  logic        stall,
  input  logic        req,
  input  logic        eret,
  input  logic        D_is_jump,
  output logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] F_pc,
  output logic [31:0] D_pc,
  output logic [31:0] D_instr,
  output logic [4:0]  D_exccode,
  output logic        D_bd,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_stall
);

  logic [0:0]  fsm_state;
  logic        in_boot;
  logic        f_adel;
  logic [31:0] f_instr;
  logic [4:0]  f_exccode;
  logic        fd_flush;
  logic [31:0] fd_bubble_pc;

  assign in_boot = (fsm_state == ST_BOOT);

  // F-stage exception check; a faulting fetch is replaced by a nop.
  assign f_adel    = is_adel(F_pc, IM_LO, IM_HI);
  assign f_instr   = f_adel ? 32'd0 : i_inst_rdata;
  assign f_exccode = f_adel ? EXC_ADEL : EXC_NONE;

  assign i_inst_addr = F_pc;

  // FSM: BOOT lasts exactly one cycle after reset, then RUN forever.
  always_ff @(posedge clk) begin
    if (!reset) fsm_state <= ST_BOOT;
    else        fsm_state <= ST_RUN;
  end

  // PC register. A misaligned or out-of-range npc is still loaded; the
  // fault is reported when that PC reaches D.
  always_ff @(posedge clk) begin
    if (!reset)     F_pc <= RESET_PC;
    else if (req)   F_pc <= HANDLER_PC;
    else if (stall) F_pc <= F_pc;
    else            F_pc <= npc;
  end

  // Bubble sources: req (even under stall), the boot cycle (even under
  // stall), and an unstalled eret which discards the wrong-path fetch.
  assign fd_flush = req || in_boot || (eret && !stall);

  always_comb begin
    fd_bubble_pc = npc;
    if (req)          fd_bubble_pc = HANDLER_PC;
    else if (in_boot) fd_bubble_pc = RESET_PC;
  end

  fd_reg #(
    .RESET_PC (RESET_PC)
  ) u_fd_reg (
    .clk        (clk),
    .reset      (reset),
    .en         (!stall),
    .flush      (fd_flush),
    .bubble_pc  (fd_bubble_pc),
    .in_pc      (F_pc),
    .in_instr   (f_instr),
    .in_exccode (f_exccode),
    .in_bd      (D_is_jump),
    .d_pc       (D_pc),
    .d_instr    (D_instr),
    .d_exccode  (D_exccode),
    .d_bd       (D_bd)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_cnt <= 32'd0;
      stall_cnt <= 32'd0;
    end else if (!in_boot) begin
      // A non-bubble load happens only on the plain "otherwise" path.
      if (!req && !stall && !eret) fetch_cnt <= fetch_cnt + 32'd1;
      if (stall && !req)           stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_fetch = fetch_cnt;
  assign perf_stall = stall_cnt;
`else
  assign perf_fetch = 32'd0;
  assign perf_stall = 32'd0;
`endif

endmodule

// File: tb/tb_f_stage_pc.sv
module tb_f_stage_pc;

  logic        clk;
  logic        reset;
  logic [31:0] npc;
  logic        stall;
  logic        req;
  logic        eret;
  logic        D_is_jump;
  logic [31:0] i_inst_addr;
  logic [31:0] i_inst_rdata;
  logic [31:0] F_pc;
  logic [31:0] D_pc;
  logic [31:0] D_instr;
  logic [4:0]  D_exccode;
  logic        D_bd;
  logic [31:0] perf_fetch;
  logic [31:0] perf_stall;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference counter model, advanced from the inputs applied at each edge.
  logic        m_boot;
  logic [31:0] m_fetch;
  logic [31:0] m_stall;

  f_stage_pc dut (
    .clk          (clk),
    .reset        (reset),
    .npc          (npc),
    .stall        (stall),
    .req          (req),
    .eret         (eret),
    .D_is_jump    (D_is_jump),
    .i_inst_addr  (i_inst_addr),
    .i_inst_rdata (i_inst_rdata),
    .F_pc         (F_pc),
    .D_pc         (D_pc),
    .D_instr      (D_instr),
    .D_exccode    (D_exccode),
    .D_bd         (D_bd),
    .perf_fetch   (perf_fetch),
    .perf_stall   (perf_stall)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 ns after it.
  task automatic tick();
    if (!reset) begin
      m_boot  = 1'b1;
      m_fetch = 32'd0;
      m_stall = 32'd0;
    end else begin
      if (!m_boot) begin
        if (!req && !stall && !eret) m_fetch = m_fetch + 32'd1;
        if (stall && !req)           m_stall = m_stall + 32'd1;
      end
      m_boot = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_d(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                         input logic [4:0] exc, input logic bd);
    check({tag, ".D_pc"}, D_pc, pc);
    check({tag, ".D_instr"}, D_instr, instr);
    check({tag, ".D_exccode"}, {27'd0, D_exccode}, {27'd0, exc});
    check({tag, ".D_bd"}, {31'd0, D_bd}, {31'd0, bd});
  endtask

  task automatic check_perf(input string tag);
`ifdef FETCH_PERF_EN
    check({tag, ".perf_fetch"}, perf_fetch, m_fetch);
    check({tag, ".perf_stall"}, perf_stall, m_stall);
`else
    check({tag, ".perf_fetch"}, perf_fetch, 32'd0);
    check({tag, ".perf_stall"}, perf_stall, 32'd0);
`endif
  endtask

  initial begin
    reset = 1'b0; npc = 32'h3004; stall = 1'b0; req = 1'b0; eret = 1'b0;
    D_is_jump = 1'b0; i_inst_rdata = 32'd0;
    m_boot = 1'b1; m_fetch = 32'd0; m_stall = 32'd0;

    // Reset held for two edges; now in BOOT.
    tick(); tick();
    check("rst.F_pc", F_pc, 32'h3000);
    check("rst.i_inst_addr", i_inst_addr, 32'h3000);
    check_d("rst", 32'h3000, 32'd0, 5'd0, 1'b0);
    check_perf("rst");

    // BOOT cycle: bubble with RESET_PC, F_pc takes npc.
    reset = 1'b1; i_inst_rdata = 32'h1111_0000;
    tick();
    check("boot.F_pc", F_pc, 32'h3004);
    check_d("boot", 32'h3000, 32'd0, 5'd0, 1'b0);

    // First real fetch.
    i_inst_rdata = 32'haaaa_0001; npc = 32'h3008;
    tick();
    check("run.F_pc", F_pc, 32'h3008);
    check_d("run", 32'h3004, 32'haaaa_0001, 5'd0, 1'b0);

    // Delay slot at 0x3008.
    D_is_jump = 1'b1; i_inst_rdata = 32'hbbbb_0002; npc = 32'h300c;
    tick();
    D_is_jump = 1'b0;
    check("ds.F_pc", F_pc, 32'h300c);
    check_d("ds", 32'h3008, 32'hbbbb_0002, 5'd0, 1'b1);
    check_perf("ds");

    // Stall for three cycles.
    stall = 1'b1; npc = 32'h3010; i_inst_rdata = 32'hcccc_0003;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall.F_pc", F_pc, 32'h300c);
      check_d("stall", 32'h3008, 32'hbbbb_0002, 5'd0, 1'b1);
    end
    stall = 1'b0;
    tick();
    check("unstall.F_pc", F_pc, 32'h3010);
    check_d("unstall", 32'h300c, 32'hcccc_0003, 5'd0, 1'b0);
    check_perf("unstall");

    // Interrupt with stall: req wins.
    req = 1'b1; stall = 1'b1; npc = 32'h3014; i_inst_rdata = 32'h1234_5678;
    tick();
    req = 1'b0; stall = 1'b0;
    check("irq.F_pc", F_pc, 32'h4180);
    check_d("irq", 32'h4180, 32'd0, 5'd0, 1'b0);

    // Misaligned npc is loaded; AdEL shows up once it reaches D.
    npc = 32'h3002; i_inst_rdata = 32'hdddd_0004;
    tick();
    check("mis.F_pc", F_pc, 32'h3002);
    check_d("hdl", 32'h4180, 32'hdddd_0004, 5'd0, 1'b0);
    npc = 32'h7000; i_inst_rdata = 32'h2408_0001;
    tick();
    check("mis2.F_pc", F_pc, 32'h7000);
    check_d("mis", 32'h3002, 32'd0, 5'd4, 1'b0);
    npc = 32'h3010;
    tick();
    check_d("hi_out", 32'h7000, 32'd0, 5'd4, 1'b0);

    // Upper boundary 0x6ffc is legal.
    npc = 32'h6ffc;
    tick();
    npc = 32'h3018;
    tick();
    check_d("hi_edge", 32'h6ffc, 32'h2408_0001, 5'd0, 1'b0);

    // Just below the window: 0x2ffc faults.
    npc = 32'h2ffc;
    tick();
    npc = 32'h3020;
    tick();
    check_d("lo_out", 32'h2ffc, 32'd0, 5'd4, 1'b0);
    check("lo_out.F_pc", F_pc, 32'h3020);
    check_perf("addr");

    // eret: redirect to EPC, wrong-path fetch dropped.
    npc = 32'h3040; tick();
    eret = 1'b1; npc = 32'h3020; i_inst_rdata = 32'h9999_9999;
    tick();
    check("eret.F_pc", F_pc, 32'h3020);
    check_d("eret", 32'h3020, 32'd0, 5'd0, 1'b0);

    // eret under stall: stall wins, everything holds.
    stall = 1'b1; npc = 32'h3050;
    tick();
    check("eret_stall.F_pc", F_pc, 32'h3020);
    check_d("eret_stall", 32'h3020, 32'd0, 5'd0, 1'b0);
    eret = 1'b0; stall = 1'b0;
    check_perf("eret");

    // Reset during req+stall: reset wins.
    npc = 32'h3060; tick();
    req = 1'b1; stall = 1'b1; reset = 1'b0;
    tick();
    check("rst2.F_pc", F_pc, 32'h3000);
    check_d("rst2", 32'h3000, 32'd0, 5'd0, 1'b0);
    check_perf("rst2");

    // BOOT with stall still held: F/D bubbles anyway, PC holds.
    req = 1'b0; reset = 1'b1; npc = 32'h3004; i_inst_rdata = 32'h5555_5555;
    tick();
    check("boot_stall.F_pc", F_pc, 32'h3000);
    check_d("boot_stall", 32'h3000, 32'd0, 5'd0, 1'b0);
    stall = 1'b0;
    tick();
    check("post_boot.F_pc", F_pc, 32'h3004);
    check_d("post_boot", 32'h3000, 32'h5555_5555, 5'd0, 1'b0);
    check_perf("end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/f_stage_pc.md
Name: f_stage_pc

Overview:
- Fetch stage of the 5-stage MIPS pipeline with precise exceptions.
- Holds the PC register and drives the instruction-memory address.
- Latches npc from the D-stage next-PC logic each cycle.
- Detects fetch address exceptions and owns the F/D pipeline register that feeds the D stage (D_pc, instruction, exception code, delay-slot flag).

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- HANDLER_PC, 32'h0000_4180, exception entry address.
- IM_LO, 32'h0000_3000, lowest legal fetch address.
- IM_HI, 32'h0000_6ffc, highest legal fetch address.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous active-low reset (reset==0 resets on the clock edge).
- npc  in  32  next PC from the D-stage next-PC logic.
- stall  in  1  hazard stall: hold the PC and the F/D register.
- req  in  1  exception/interrupt taken this cycle (from CP0).
- eret  in  1  eret in D this cycle.
- D_is_jump  in  1  D instruction is a branch or jump; marks the next fetch as a delay slot.
- i_inst_addr  out  32  instruction memory address; equals F_pc.
- i_inst_rdata  in  32  instruction word, combinational read.
- F_pc  out  32  current fetch PC.
- D_pc  out  32  F/D register: PC.
- D_instr  out  32  F/D register: instruction (0 = nop).
- D_exccode  out  5  F/D register: exception code (0 = none, 4 = AdEL).
- D_bd  out  1  F/D register: delay-slot flag.
- perf_fetch  out  32  fetch counter; 0 when the optional feature is off.
- perf_stall  out  32  stall counter; 0 when the optional feature is off.

Behaviour:
- F-stage exception check (combinational):
  - F_adel = (F_pc[1:0] != 0) or F_pc < IM_LO or F_pc > IM_HI.
  - F_instr = F_adel ? 0 : i_inst_rdata.
  - F_exccode = F_adel ? 4 : 0.
  - F_bd = D_is_jump.
- Per-edge priority, highest first:
  1. reset==0: F_pc=RESET_PC; D_pc=RESET_PC; D_instr=0; D_exccode=0; D_bd=0; counters=0.
  2. req: F_pc=HANDLER_PC; F/D loaded with a bubble with D_pc=HANDLER_PC, D_instr=0, D_exccode=0, D_bd=0. req overrides stall.
  3. stall: F_pc and the F/D register hold.
  4. eret: F_pc=npc (EPC); F/D loaded with a bubble with D_pc=npc. The wrong-path instruction is discarded; eret has no delay slot.
  5. Otherwise: F_pc=npc; F/D loads {F_pc, F_instr, F_exccode, F_bd}.
- Latency:
  - npc becomes F_pc one cycle later.
  - An instruction fetched in cycle n is in D in cycle n+1, if not stalled.
- A misaligned npc is still loaded into F_pc. The AdEL is flagged when that PC reaches D.
- No wrap-around handling: PC arithmetic is 32-bit modulo.
- Reset asserted mid-stall or mid-req: reset wins unconditionally.
- FSM, two states:
  - BOOT: entered on reset. Lasts exactly one cycle. The F/D register loads a bubble (D_pc=RESET_PC) regardless of stall.
  - RUN: normal operation per the priority list above.
  - Transition BOOT->RUN occurs unconditionally after one cycle.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - perf_fetch increments on every RUN cycle that loads a non-bubble into F/D.
  - perf_stall increments on every RUN cycle with stall=1 and req=0.
  - Both counters are 32-bit and wrap modulo 2^32. Both clear on reset.
- Undefined: no counter registers are instantiated; both perf outputs are tied to 0.

Decomposition:
- Shared const package holds:
  - EXC_NONE=0 and EXC_ADEL=4.
  - The RESET_PC, HANDLER_PC, IM_LO and IM_HI defaults.
  - The BOOT/RUN state encodings.
- One sub-module, fd_reg: the F/D pipeline register with enable (~stall) and flush inputs, plus the bubble PC value.
- The PC register and FSM stay in the top module.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then release with npc=0x3004.
  -> F_pc=0x3000 and D_instr=0 during BOOT; next cycle F_pc=0x3004 and D_pc=0x3000.
- Stall: set stall=1 for 3 cycles with npc=0x3010 and F_pc=0x300c.
  -> F_pc stays 0x300c and D outputs stay unchanged; after release, F_pc=0x3010.
- Interrupt under stall: req=1 and stall=1 together.
  -> next cycle F_pc=0x4180, D_pc=0x4180, D_instr=0, D_exccode=0.
- Misaligned fetch: npc=0x3002 is loaded, then one more edge.
  -> D_exccode=4 and D_instr=0 while i_inst_rdata=0x2408_0001; also covers out-of-range npc=0x7000.
- eret: eret=1 with npc=0x3020.
  -> next cycle F_pc=0x3020, D_instr=0, D_pc=0x3020.
- Delay slot: D_is_jump=1 in the cycle fetching 0x3008.
  -> D_bd=1 with D_pc=0x3008. With FETCH_PERF_EN defined, perf_fetch counts exactly the non-bubble loads.
